// File: rtl/ps2_pkg.sv
// Shared FSM state encoding and frame-size helper for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DELAY     = 3'd1,
        SAMPLE    = 3'd2,
        WAIT_EDGE = 3'd3,
        CHECK     = 3'd4
    } ps2_state_e;

    // Start + payload + parity + stop.
    function automatic int FRAME_BITS(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through FIFO: head visible the cycle after a push into an empty FIFO.
// A push into a full FIFO succeeds only when a pop is accepted in the same cycle.
module ps2_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          ck,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             head_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              push_eff;
    logic              pop_eff;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_eff   = pop && !empty;
    assign push_eff  = push && (!full || pop_eff);
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        if (push_eff && !pop_eff) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_eff && pop_eff) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_eff) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset; the head is masked while empty.
    always_ff @(posedge ck) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: frame assembly, start/stop/parity/timeout checks, FWFT output FIFO (word valid 1 cycle after CHECK).
// No backpressure to the device; full FIFO drops words with an overflow pulse. Optional PS2_RX_GLITCH_FILTER_EN.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SAMPLE_DLY  = 130,
    parameter int TIMEOUT     = 3700,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8
) (
    input  logic                          ck,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [2:0]                    curr_state
);

    localparam int N     = FRAME_BITS(DATA_W);
    localparam int BIT_W = $clog2(N + 1);
    localparam int DLY_W = $clog2(SAMPLE_DLY + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   sclk;
    logic                   sdata;
    logic                   prev_sclk_q;
    logic                   fe;

    ps2_state_e             state_q;
    logic [BIT_W-1:0]       bitcnt_q;
    logic [DLY_W-1:0]       dly_cnt_q;
    logic [TO_W-1:0]        to_cnt_q;
    logic [N-1:0]           sh_q;
    logic                   parity_err_q;
    logic                   frame_err_q;
    logic                   overflow_q;

    logic                   bad_frame;
    logic                   bad_parity;
    logic                   good_word;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Idle-high reset value keeps the first cycles after reset from looking like an edge.
    always_ff @(posedge ck) begin
        if (reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign sdata = dat_sync_q[SYNC_STAGES-1];

`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic          filt_q;
    logic [FW-1:0] filt_cnt_q;

    always_ff @(posedge ck) begin
        if (reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_sync_q[SYNC_STAGES-1] == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
            filt_q     <= clk_sync_q[SYNC_STAGES-1];
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + FW'(1);
        end
    end

    assign sclk = filt_q;
`else
    assign sclk = clk_sync_q[SYNC_STAGES-1];
`endif

    assign fe = prev_sclk_q && !sclk;

    // sh_q[0] = start, sh_q[DATA_W:1] = payload, then parity, then stop.
    assign bad_frame  = sh_q[0] || !sh_q[N-1];
    assign bad_parity = !(^sh_q[N-2:1]);
    assign good_word  = !bad_frame && !bad_parity;
    assign push       = (state_q == CHECK) && good_word;
    assign pop        = rd_valid && rd_ready;

    always_ff @(posedge ck) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_sclk_q  <= 1'b1;
            bitcnt_q     <= '0;
            dly_cnt_q    <= '0;
            to_cnt_q     <= '0;
            sh_q         <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            prev_sclk_q  <= sclk;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fe) begin
                        state_q   <= DELAY;
                        bitcnt_q  <= '0;
                        to_cnt_q  <= '0;
                        dly_cnt_q <= '0;
                    end
                end
                DELAY, SAMPLE, WAIT_EDGE: begin
                    // Timeout wins over an edge arriving in the same cycle.
                    if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        to_cnt_q <= fe ? '0 : to_cnt_q + TO_W'(1);
                        if (state_q == DELAY) begin
                            if (dly_cnt_q == DLY_W'(SAMPLE_DLY - 1)) begin
                                state_q   <= SAMPLE;
                                dly_cnt_q <= '0;
                            end else begin
                                dly_cnt_q <= dly_cnt_q + DLY_W'(1);
                            end
                        end else if (state_q == SAMPLE) begin
                            sh_q     <= {sdata, sh_q[N-1:1]};
                            bitcnt_q <= bitcnt_q + BIT_W'(1);
                            state_q  <= (bitcnt_q == BIT_W'(N - 1)) ? CHECK : WAIT_EDGE;
                        end else if (fe) begin
                            state_q   <= DELAY;
                            dly_cnt_q <= '0;
                        end
                    end
                end
                CHECK: begin
                    state_q      <= IDLE;
                    frame_err_q  <= bad_frame;
                    parity_err_q <= !bad_frame && bad_parity;
                    overflow_q   <= good_word && fifo_full && !pop;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    ps2_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ck        (ck),
        .reset     (reset),
        .push      (push),
        .push_data (sh_q[DATA_W:1]),
        .pop       (pop),
        .head_data (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rd_valid   = !fifo_empty;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign curr_state = state_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised PS/2 frame stimulus with a queue-based scoreboard and FIFO reference model.
module tb_ps2_rx_fifo;

    localparam int DEPTH    = 4;
    localparam int ST_IDLE  = 0;
    localparam int ST_CHECK = 4;
    localparam int EV_GOOD  = 0;
    localparam int EV_PAR   = 1;
    localparam int EV_FRM   = 2;
    localparam int EV_TO    = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic [2:0] curr_state;

    int   vectors = 0;
    int   miscompares = 0;
    ev_t  evq[$];
    logic [7:0] mq[$];
    bit   exp_pe = 0;
    bit   exp_fe = 0;
    bit   exp_ov = 0;
    bit   frames_done = 0;

    ps2_rx_fifo #(
        .DATA_W      (8),
        .SAMPLE_DLY  (4),
        .TIMEOUT     (50),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2),
        .FILT_LEN    (8)
    ) dut (
        .ck         (ck),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fifo_count (fifo_count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .curr_state (curr_state)
    );

    always #5 ck = ~ck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    // PS/2 device: data changes mid-high, 40-cycle clock period.
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(10);
            ps2_clk = 1'b0;
            tick(20);
            ps2_clk = 1'b1;
            tick(10);
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] make_bits(input logic [7:0] d, input logic start_b,
                                              input logic par_ok, input logic stop_b);
        logic par;
        par = ~(^d);
        if (!par_ok) par = ~par;
        return {stop_b, par, d, start_b};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic start_b,
                              input logic par_ok, input logic stop_b);
        logic [10:0] bits;
        ev_t ev;
        bits = make_bits(d, start_b, par_ok, stop_b);
        ev.data = d;
        if (start_b != 1'b0 || stop_b != 1'b1) ev.kind = EV_FRM;
        else if (((^d) ^ bits[9]) != 1'b1)     ev.kind = EV_PAR;
        else                                   ev.kind = EV_GOOD;
        evq.push_back(ev);
        send_bits(bits, 11);
        tick(30);
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        tick(n);
        rd_ready = 1'b0;
    endtask

    // Monitor / scoreboard: samples on the falling edge, model advances per rising edge.
    always @(negedge ck) begin
        bit   efe;
        bit   popped;
        ev_t  ev;
        if (reset) begin
            mq.delete();
            exp_pe = 0;
            exp_fe = 0;
            exp_ov = 0;
        end else begin
            efe = exp_fe;
            if (frame_err && !efe && evq.size() > 0 && evq[0].kind == EV_TO) begin
                void'(evq.pop_front());
                efe = 1;
                check("timeout_state_idle", curr_state, ST_IDLE);
            end
            check("parity_err", parity_err, exp_pe);
            check("frame_err", frame_err, efe);
            check("overflow", overflow, exp_ov);
            check("rd_valid", rd_valid, mq.size() > 0);
            check("fifo_count", fifo_count, mq.size());
            if (mq.size() > 0) check("rd_data", rd_data, mq[0]);

            exp_pe = 0;
            exp_fe = 0;
            exp_ov = 0;
            popped = (mq.size() > 0) && rd_ready;
            if (popped) void'(mq.pop_front());
            if (curr_state == ST_CHECK) begin
                if (evq.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    ev = evq.pop_front();
                    case (ev.kind)
                        EV_FRM:  exp_fe = 1;
                        EV_PAR:  exp_pe = 1;
                        EV_GOOD: begin
                            if (mq.size() < DEPTH) mq.push_back(ev.data);
                            else                   exp_ov = 1;
                        end
                        default: check("check_instead_of_timeout", ev.kind, EV_TO + 1);
                    endcase
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit   seen;
        ev_t  ev;
        logic [7:0] d;
        int   r;

        tick(5);
        check("reset_state", curr_state, ST_IDLE);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_count", fifo_count, 0);
        check("reset_pulses", {parity_err, frame_err, overflow}, 0);
        reset = 1'b0;
        tick(20);

        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);

        // Abort after five bits: clock stays high long past the timeout.
        ev.kind = EV_TO;
        ev.data = 8'h00;
        evq.push_back(ev);
        send_bits(make_bits(8'h5A, 1'b0, 1'b1, 1'b1), 5);
        tick(60);
        send_frame(8'h12, 1'b0, 1'b1, 1'b1);
        drain(6);
        tick(5);

        // Fill the FIFO; the fifth good word overflows.
        for (int i = 0; i < 5; i++) begin
            send_frame(8'($urandom), 1'b0, 1'b1, 1'b1);
        end

        // Pop exactly during CHECK of a good frame while full.
        seen = 0;
        fork
            send_frame(8'($urandom), 1'b0, 1'b1, 1'b1);
            begin
                for (int c = 0; c < 700 && !seen; c++) begin
                    tick(1);
                    if (curr_state == ST_CHECK) begin
                        seen = 1;
                        rd_ready = 1'b1;
                        tick(1);
                        rd_ready = 1'b0;
                    end
                end
            end
        join
        check("check_cycle_seen", seen, 1);

        // Random frames with random errors and a random consumer.
        frames_done = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    d = 8'($urandom);
                    r = $urandom_range(0, 5);
                    send_frame(d, r == 0, r != 2, r != 1);
                end
                frames_done = 1;
            end
            begin
                while (!frames_done) begin
                    rd_ready = 1'($urandom_range(0, 1));
                    tick(1);
                end
                rd_ready = 1'b0;
            end
        join

        // Reset in the middle of a frame.
        send_frame(8'h77, 1'b0, 1'b1, 1'b1);
        send_bits(make_bits(8'h99, 1'b0, 1'b1, 1'b1), 6);
        reset = 1'b1;
        tick(1);
        check("midreset_state", curr_state, ST_IDLE);
        check("midreset_rd_valid", rd_valid, 0);
        check("midreset_count", fifo_count, 0);
        reset = 1'b0;
        tick(20);

        send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
        drain(10);
        tick(20);
        check("events_outstanding", evq.size(), 0);
        check("model_fifo_empty", mq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
